// File: rtl/joybus_port_sched.sv
// Shared-engine scheduler for four JOYBUS controller ports: periodic status
// polls of enabled ports, with one-off host commands taking priority.
module joybus_port_sched #(
  parameter int POLL_CYCLES    = 500000,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   port_en,
  input  logic         req_valid,
  input  logic [1:0]   req_port,
  input  logic [7:0]   req_cmd,
  output logic         req_ack,
  output logic [1:0]   port_sel,
  output logic         cmd_rdy,
  output logic [7:0]   cmd_data,
  input  logic         rx_done,
  input  logic [7:0]   rx_status,
  input  logic [31:0]  rx_data,
  output logic [127:0] cntlr_data,
  output logic [3:0]   present,
  output logic [3:0]   timeout_err,
  output logic         rsp_valid,
  output logic [7:0]   rsp_status,
  output logic [31:0]  rsp_data,
  output logic         busy
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RX = 2'd2;
  localparam logic [1:0] STORE   = 2'd3;

  localparam logic [7:0] POLL_CMD  = 8'h01;
  localparam logic [7:0] STATUS_OK = 8'h05;

  logic [1:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] wait_cnt;
  logic          round_pending;
  logic [3:0]    round_mask;
  logic          is_host;
  logic          timed_out;
  logic [7:0]    rx_st_q;
  logic [31:0]   rx_dat_q;

  function automatic logic [1:0] lowest_port(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      wait_cnt      <= '0;
      round_pending <= 1'b0;
      round_mask    <= '0;
      is_host       <= 1'b0;
      timed_out     <= 1'b0;
      rx_st_q       <= '0;
      rx_dat_q      <= '0;
      port_sel      <= '0;
      cmd_rdy       <= 1'b0;
      cmd_data      <= '0;
      req_ack       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      rsp_data      <= '0;
      cntlr_data    <= '0;
      present       <= '0;
      timeout_err   <= '0;
    end else begin
      cmd_rdy   <= 1'b0;
      req_ack   <= 1'b0;
      rsp_valid <= 1'b0;

      // Poll timer only runs while idle with no round outstanding; a pending
      // round pins it at zero so a late expiry cannot stretch the round.
      if (state == IDLE && !round_pending) begin
        if (poll_cnt == POLL_LAST) begin
          poll_cnt      <= '0;
          round_pending <= 1'b1;
          round_mask    <= port_en;
        end else begin
          poll_cnt <= poll_cnt + 1'b1;
        end
      end else if (round_pending) begin
        poll_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ack  <= 1'b1;
            port_sel <= req_port;
            cmd_data <= req_cmd;
            cmd_rdy  <= 1'b1;
            is_host  <= 1'b1;
            state    <= ISSUE;
          end else if (round_pending) begin
            if (round_mask != 4'b0000) begin
              port_sel <= lowest_port(round_mask);
              cmd_data <= POLL_CMD;
              cmd_rdy  <= 1'b1;
              is_host  <= 1'b0;
              state    <= ISSUE;
            end else begin
              round_pending <= 1'b0;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_RX;
        end
        WAIT_RX: begin
          if (rx_done) begin
            rx_st_q   <= rx_status;
            rx_dat_q  <= rx_data;
            timed_out <= 1'b0;
            state     <= STORE;
          end else if (wait_cnt == TO_LAST) begin
            timed_out <= 1'b1;
            state     <= STORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STORE: begin
          if (is_host) begin
            rsp_valid  <= 1'b1;
            rsp_status <= timed_out ? 8'hFF : rx_st_q;
            rsp_data   <= timed_out ? 32'h0 : rx_dat_q;
          end else begin
            if (!timed_out && rx_st_q == STATUS_OK) begin
              cntlr_data[{port_sel, 5'd0} +: 32] <= rx_dat_q;
              present[port_sel]     <= 1'b1;
              timeout_err[port_sel] <= 1'b0;
            end else begin
              cntlr_data[{port_sel, 5'd0} +: 32] <= 32'h0;
              present[port_sel] <= 1'b0;
              if (timed_out) timeout_err[port_sel] <= 1'b1;
            end
            round_mask[port_sel] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
